// File: rtl/spi_ram_arbiter_if.sv
// Request/acknowledge and RAM-side signals shared by the config-RAM arbiter.
// slave is the arbiter's view; master is the requesters-plus-RAM environment.
interface spi_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  p0_req;
  logic                  p0_we;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic                  p0_ack;
  logic                  p0_err;
  logic [DATA_WIDTH-1:0] p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic                  p1_ack;
  logic                  p1_err;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
    input  ram_rdata,
    output busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
    output ram_rdata,
    input  busy
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-port round-robin arbiter for the single-port config RAM: one access every three
// cycles (IDLE -> ACCESS -> RESP), registered RAM controls and a one-cycle ack per port.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 32
) (
  input logic               clk,
  input logic               rstn,
  spi_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  port_q;
  logic                  we_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  ram_cs_q, ram_we_q, ram_oe_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  p0_ack_q, p0_err_q, p1_ack_q, p1_err_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;

  logic                  elig0, elig1, gnt_any, gnt1, addr_ok, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A port whose ack is still high is dropping its request this cycle; ignore it.
  always_comb begin
    elig0     = bus.p0_req & ~p0_ack_q;
    elig1     = bus.p1_req & ~p1_ack_q;
    gnt_any   = elig0 | elig1;
    gnt1      = elig1 & (~elig0 | ~last_grant_q);
    sel_we    = gnt1 ? bus.p1_we    : bus.p0_we;
    sel_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;
    addr_ok   = 32'(sel_addr) < DEPTH;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      ram_cs_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_oe_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      p0_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_ack_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p1_rdata_q   <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p0_err_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p1_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (gnt_any) begin
            state_q      <= StAccess;
            busy_q       <= 1'b1;
            port_q       <= gnt1;
            last_grant_q <= gnt1;
            we_q         <= sel_we;
            err_q        <= ~addr_ok;
            ram_cs_q     <= addr_ok;
            ram_we_q     <= addr_ok & sel_we;
            ram_oe_q     <= addr_ok & ~sel_we;
            ram_addr_q   <= sel_addr;
            ram_wdata_q  <= sel_wdata;
          end
        end
        StAccess: begin
          state_q  <= StResp;
          ram_cs_q <= 1'b0;
          ram_we_q <= 1'b0;
          ram_oe_q <= 1'b0;
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!port_q) begin
            p0_ack_q <= 1'b1;
            p0_err_q <= err_q;
            if (err_q)      p0_rdata_q <= '0;
            else if (!we_q) p0_rdata_q <= bus.ram_rdata;
          end else begin
            p1_ack_q <= 1'b1;
            p1_err_q <= err_q;
            if (err_q)      p1_rdata_q <= '0;
            else if (!we_q) p1_rdata_q <= bus.ram_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.p0_ack    = p0_ack_q;
  assign bus.p0_err    = p0_err_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p1_err    = p1_err_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_oe    = ram_oe_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port synchronous config RAM (32 x 24-bit) between two requesters: port 0 (SPI frame engine) and port 1 (host/register side).
- Serialises accesses with a 3-state FSM and round-robin arbitration, drives the RAM control signals, and returns read data with a one-cycle ack pulse.
- Uses split write/read data buses; the bidirectional RAM data bus is resolved outside this block.

Parameters:
ADDR_WIDTH, 5, RAM address width
DATA_WIDTH, 24, RAM word width
DEPTH, 32, number of implemented words (must be <= 2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
p0_req  input  1  port 0 access request, level, held until p0_ack
p0_we  input  1  port 0: 1=write, 0=read; stable while p0_req
p0_addr  input  ADDR_WIDTH  port 0 address; stable while p0_req
p0_wdata  input  DATA_WIDTH  port 0 write data; stable while p0_req
p0_ack  output  1  port 0 completion pulse, one cycle
p0_err  output  1  port 0 address-error flag, valid with p0_ack
p0_rdata  output  DATA_WIDTH  port 0 read data, valid with p0_ack, held until next p0 ack
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata  (same directions, widths and meanings as port 0, for port 1)
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM read enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_rdata  input  DATA_WIDTH  RAM read data, valid one cycle after the read edge
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs 0; last_grant=1, so port 0 wins the first tie. Any in-flight access is dropped and no ack is issued.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - Eligible port = req high AND its ack not currently high. This masks the cycle in which the requester is still dropping req.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - On grant at edge E0: latch port id, we, addr, wdata; set last_grant; go to ACCESS.
  - If addr < DEPTH: drive ram_cs=1, ram_we=we, ram_oe=~we, ram_addr, ram_wdata, valid for the ACCESS cycle.
  - If addr >= DEPTH: keep ram_cs=0 and set the internal err flag.
- ACCESS: at E1, RAM performs the operation. Controller deasserts ram_cs, ram_we and ram_oe (ram_addr/ram_wdata may hold) and goes to RESP.
- RESP: at E2, go to IDLE and, for the granted port only:
  - ack<=1, err<=err flag.
  - Read without error: rdata<=ram_rdata.
  - Write, or error: rdata unchanged for a write; rdata<=0 on error.
- ack/err clear at the next edge (E3): one-cycle pulse.
- Latency: req sampled at E0 -> ack high during the cycle after E2. Throughput is one access per 3 cycles; back-to-back grant is possible at E3.
- Requester must drop req in the cycle ack is high; if req is still high at the following edge, it is a new request.
- Req dropped before grant: no access, no ack. Req dropped after grant: access completes and ack is still pulsed.
- Never more than one RAM cycle in flight; ram_we and ram_oe are never both high.
- Addresses wrap nowhere: address DEPTH-1 is valid, DEPTH is an error.

Test Plan:
- Single write then read, port 0: write addr 5 data 0xA5A5A5, then read addr 5 -> ram_cs high exactly 1 cycle each; p0_ack 3 cycles after req sampled; p0_rdata=0xA5A5A5; p0_err=0.
- Simultaneous requests after reset: p0 and p1 both request reads -> p0 granted first, p1 acked 3 cycles later. Both continuously re-requesting -> grants alternate 0,1,0,1.
- Port 1 writes addr 31 data 0x123456, then port 0 reads addr 31 -> p0_rdata=0x123456; p1_rdata unchanged.
- Out-of-range with DEPTH=24, read addr 30 -> ram_cs never asserts; p0_ack=1, p0_err=1, p0_rdata=0.
- Reset mid-operation: assert rstn=0 during ACCESS -> ram_cs, busy and acks go 0 immediately. After release, first grant goes to port 0 and no stale ack appears.
- Held req: p0 keeps req high after ack -> masked in the ack cycle, re-granted at the next edge. RAM is never driven with ram_we and ram_oe both high.
